multimode_counter: RTL and testbench

MULTIMODE_COUNTER -- requirements
Module: multimode_counter

---
 rtl/multimode_counter.sv | 104 ++++++++++
 tb/tb_multimode_counter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/multimode_counter.sv
// Multimode N-bit counter: binary, Gray, ring and Johnson sequences with
// direction control, validated parallel load and terminal-count pulse.
module multimode_counter #(
   parameter int unsigned N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         dir,
   input  logic [1:0]   mode,
   input  logic         load,
   input  logic [N-1:0] load_val,
   output logic [N-1:0] q,
   output logic         tc,
   output logic         load_err
);

   typedef enum logic [1:0] {
      MODE_BIN  = 2'b00,
      MODE_GRAY = 2'b01,
      MODE_RING = 2'b10,
      MODE_JOHN = 2'b11
   } mode_e;

   mode_e        mode_q, mode_d, mode_in;
   logic [N-1:0] cnt_q, cnt_d;
   logic [N-1:0] idx_q, idx_d;
   logic         tc_q, tc_d;
   logic         err_q, err_d;

   function automatic logic [N-1:0] seed_of(input mode_e m);
      return (m == MODE_RING) ? N'(1) : '0;
   endfunction

   function automatic logic is_onehot(input logic [N-1:0] v);
      return (v != '0) && ((v & (v - N'(1))) == '0);
   endfunction

   // Legal Johnson states have at most one 0/1 boundary between adjacent bits.
   function automatic logic is_johnson(input logic [N-1:0] v);
      int unsigned edges;
      edges = 0;
      for (int unsigned i = 0; i < N - 1; i++)
         edges += {31'd0, v[i] ^ v[i+1]};
      return edges <= 1;
   endfunction

   assign mode_in = mode_e'(mode);

   always_comb begin
      mode_d = mode_q;
      cnt_d  = cnt_q;
      idx_d  = idx_q;
      tc_d   = 1'b0;
      err_d  = 1'b0;
      if (rst || (mode_in != mode_q)) begin
         mode_d = mode_in;
         cnt_d  = seed_of(mode_in);
         idx_d  = '0;
      end else if (load) begin
         unique case (mode_q)
            MODE_BIN:  cnt_d = load_val;
            MODE_GRAY: begin
               idx_d = load_val;
               cnt_d = load_val ^ (load_val >> 1);
            end
            MODE_RING: begin
               cnt_d = is_onehot(load_val) ? load_val : seed_of(MODE_RING);
               err_d = !is_onehot(load_val);
            end
            MODE_JOHN: begin
               cnt_d = is_johnson(load_val) ? load_val : seed_of(MODE_JOHN);
               err_d = !is_johnson(load_val);
            end
         endcase
      end else if (en) begin
         unique case (mode_q)
            MODE_BIN:  cnt_d = dir ? cnt_q + N'(1) : cnt_q - N'(1);
            MODE_GRAY: begin
               idx_d = dir ? idx_q + N'(1) : idx_q - N'(1);
               cnt_d = idx_d ^ (idx_d >> 1);
            end
            MODE_RING: cnt_d = dir ? {cnt_q[0], cnt_q[N-1:1]}
                                   : {cnt_q[N-2:0], cnt_q[N-1]};
            MODE_JOHN: cnt_d = dir ? {~cnt_q[0], cnt_q[N-1:1]}
                                   : {cnt_q[N-2:0], ~cnt_q[N-1]};
         endcase
         tc_d = (cnt_d == seed_of(mode_q));
      end
   end

   always_ff @(posedge clk) begin
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      tc_q   <= tc_d;
      err_q  <= err_d;
   end

   assign q        = cnt_q;
   assign tc       = tc_q;
   assign load_err = err_q;

endmodule

// File: tb/tb_multimode_counter.sv
// Vector-table and hand-sequence bench for multimode_counter (N=4) with an
// expected-result queue popped one cycle after each stimulus.
module tb_multimode_counter;

   logic       clk = 1'b0;
   logic       rst, en, dir, load;
   logic [1:0] mode;
   logic [3:0] load_val;
   logic [3:0] q;
   logic       tc, load_err;

   typedef struct {
      logic       rst, en, dir;
      logic [1:0] mode;
      logic       load;
      logic [3:0] lv;
      logic [3:0] eq;
      logic       etc, eerr;
      string      name;
   } vec_t;

   typedef struct {
      logic [3:0] q;
      logic       tc, err;
      string      name;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;

   multimode_counter #(.N(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .dir      (dir),
      .mode     (mode),
      .load     (load),
      .load_val (load_val),
      .q        (q),
      .tc       (tc),
      .load_err (load_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic step(input logic r, input logic e, input logic d, input logic [1:0] m,
                       input logic l, input logic [3:0] lv, input logic [3:0] eq,
                       input logic etc, input logic eerr, input string nm);
      exp_t x;
      exp_t got;
      rst = r; en = e; dir = d; mode = m; load = l; load_val = lv;
      x.q = eq; x.tc = etc; x.err = eerr; x.name = nm;
      sb.push_back(x);
      @(posedge clk);
      #1;
      checks++;
      if (sb.size() == 0) begin
         failures++;
         $display("FAIL %s: scoreboard empty", nm);
      end else begin
         got = sb.pop_front();
         if (q !== got.q || tc !== got.tc || load_err !== got.err) begin
            failures++;
            $display("FAIL %s: actual q=%b tc=%b load_err=%b required q=%b tc=%b load_err=%b",
                     got.name, q, tc, load_err, got.q, got.tc, got.err);
         end
      end
   endtask

   task automatic add(input logic r, input logic e, input logic d, input logic [1:0] m,
                      input logic l, input logic [3:0] lv, input logic [3:0] eq,
                      input logic etc, input logic eerr, input string nm);
      vec_t v;
      v.rst = r; v.en = e; v.dir = d; v.mode = m; v.load = l; v.lv = lv;
      v.eq = eq; v.etc = etc; v.eerr = eerr; v.name = nm;
      vecs.push_back(v);
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; dir = 1'b1; mode = 2'b00; load = 1'b0; load_val = '0;

      // ring: reset, forward lap, hold, reverse step
      add(1,1,1,2'b10,1,4'b0110, 4'b0001,0,0, "ring_reset");
      add(0,1,1,2'b10,0,4'b0000, 4'b1000,0,0, "ring_up1");
      add(0,1,1,2'b10,0,4'b0000, 4'b0100,0,0, "ring_up2");
      add(0,1,1,2'b10,0,4'b0000, 4'b0010,0,0, "ring_up3");
      add(0,1,1,2'b10,0,4'b0000, 4'b0001,1,0, "ring_up_tc");
      add(0,0,0,2'b10,0,4'b0000, 4'b0001,0,0, "ring_hold");
      add(0,1,0,2'b10,0,4'b0000, 4'b0010,0,0, "ring_down1");
      // johnson: reset, full forward lap, reverse retrace
      add(1,0,1,2'b11,0,4'b0000, 4'b0000,0,0, "john_reset");
      add(0,1,1,2'b11,0,4'b0000, 4'b1000,0,0, "john_u1");
      add(0,1,1,2'b11,0,4'b0000, 4'b1100,0,0, "john_u2");
      add(0,1,1,2'b11,0,4'b0000, 4'b1110,0,0, "john_u3");
      add(0,1,1,2'b11,0,4'b0000, 4'b1111,0,0, "john_u4");
      add(0,1,1,2'b11,0,4'b0000, 4'b0111,0,0, "john_u5");
      add(0,1,1,2'b11,0,4'b0000, 4'b0011,0,0, "john_u6");
      add(0,1,1,2'b11,0,4'b0000, 4'b0001,0,0, "john_u7");
      add(0,1,1,2'b11,0,4'b0000, 4'b0000,1,0, "john_u8_tc");
      add(0,1,0,2'b11,0,4'b0000, 4'b0001,0,0, "john_d1");
      add(0,1,0,2'b11,0,4'b0000, 4'b0011,0,0, "john_d2");
      add(0,1,0,2'b11,0,4'b0000, 4'b0111,0,0, "john_d3");
      add(0,1,0,2'b11,0,4'b0000, 4'b1111,0,0, "john_d4");
      add(0,1,0,2'b11,0,4'b0000, 4'b1110,0,0, "john_d5");
      add(0,1,0,2'b11,0,4'b0000, 4'b1100,0,0, "john_d6");
      add(0,1,0,2'b11,0,4'b0000, 4'b1000,0,0, "john_d7");
      add(0,1,0,2'b11,0,4'b0000, 4'b0000,1,0, "john_d8_tc");
      // gray: count, load, step, reverse through zero
      add(1,0,1,2'b01,0,4'b0000, 4'b0000,0,0, "gray_reset");
      add(0,1,1,2'b01,0,4'b0000, 4'b0001,0,0, "gray_u1");
      add(0,1,1,2'b01,0,4'b0000, 4'b0011,0,0, "gray_u2");
      add(0,1,1,2'b01,0,4'b0000, 4'b0010,0,0, "gray_u3");
      add(0,1,1,2'b01,0,4'b0000, 4'b0110,0,0, "gray_u4");
      add(0,1,1,2'b01,1,4'b0101, 4'b0111,0,0, "gray_load");
      add(0,1,1,2'b01,0,4'b0000, 4'b0101,0,0, "gray_after_load");
      add(0,0,0,2'b01,1,4'b0001, 4'b0001,0,0, "gray_load1");
      add(0,1,0,2'b01,0,4'b0000, 4'b0000,1,0, "gray_down_tc");
      add(0,1,0,2'b01,0,4'b0000, 4'b1000,0,0, "gray_wrap_down");
      // load validation in ring and johnson
      add(0,0,1,2'b10,0,4'b0000, 4'b0001,0,0, "to_ring");
      add(0,0,1,2'b10,1,4'b0110, 4'b0001,0,1, "ring_bad_load");
      add(0,0,1,2'b10,0,4'b0000, 4'b0001,0,0, "ring_err_clears");
      add(0,0,1,2'b10,1,4'b0000, 4'b0001,0,1, "ring_zero_load");
      add(0,0,1,2'b10,1,4'b0100, 4'b0100,0,0, "ring_good_load");
      add(0,0,1,2'b11,1,4'b1010, 4'b0000,0,0, "to_john_load_ignored");
      add(0,0,1,2'b11,1,4'b1010, 4'b0000,0,1, "john_bad_load");
      add(0,0,1,2'b11,1,4'b0011, 4'b0011,0,0, "john_good_load");
      add(0,0,1,2'b11,1,4'b1000, 4'b1000,0,0, "john_good_load2");
      add(0,1,1,2'b11,0,4'b0000, 4'b1100,0,0, "john_step_after_load");
      add(1,1,1,2'b10,1,4'b0110, 4'b0001,0,0, "rst_beats_bad_load");

      foreach (vecs[i])
         step(vecs[i].rst, vecs[i].en, vecs[i].dir, vecs[i].mode, vecs[i].load, vecs[i].lv,
              vecs[i].eq, vecs[i].etc, vecs[i].eerr, vecs[i].name);

      // binary: full descending lap from reset, then load beats en
      step(1,0,0,2'b00,0,4'b0000, 4'b0000,0,0, "bin_reset");
      step(0,1,0,2'b00,0,4'b0000, 4'b1111,0,0, "bin_wrap_down");
      for (int k = 14; k >= 1; k--)
         step(0,1,0,2'b00,0,4'b0000, 4'(k),0,0, "bin_down");
      step(0,1,0,2'b00,0,4'b0000, 4'b0000,1,0, "bin_down_tc");
      step(0,1,0,2'b00,1,4'b1010, 4'b1010,0,0, "bin_load_wins");
      step(0,0,1,2'b00,0,4'b0000, 4'b1010,0,0, "bin_hold_dirflip");
      step(0,1,1,2'b00,1,4'b1111, 4'b1111,0,0, "bin_load_max");
      step(0,1,1,2'b00,0,4'b0000, 4'b0000,1,0, "bin_wrap_up_tc");
      step(0,1,0,2'b00,0,4'b0000, 4'b1111,0,0, "bin_dir_flip");

      // mode change overrides load and en; reset mid-count restarts from seed
      step(0,0,1,2'b00,1,4'b0101, 4'b0101,0,0, "bin_load_0101");
      step(0,1,1,2'b10,1,4'b0110, 4'b0001,0,0, "mode_change_wins");
      step(0,1,1,2'b10,0,4'b0000, 4'b1000,0,0, "ring_count");
      step(0,1,1,2'b10,0,4'b0000, 4'b0100,0,0, "ring_count2");
      step(1,1,1,2'b10,0,4'b0000, 4'b0001,0,0, "rst_mid_count");
      step(0,1,1,2'b10,0,4'b0000, 4'b1000,0,0, "resume_after_rst");

      if (sb.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL scoreboard_drain: actual %0d entries left, required 0", sb.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
